// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg: shared PCI arbitration types and constants
package pci_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, OWN, GAP} req_state_t;
    localparam logic ASSERTED_N   = 1'b0;
    localparam logic DEASSERTED_N = 1'b1;
    localparam int   NUM_AGENTS   = 4;
endpackage

// File: rtl/pci_bus_requester_if.sv
// pci_bus_requester_if: engine/arbiter/bus signals seen by one PCI requester
interface pci_bus_requester_if;
    logic xfer_req, xfer_done, gnt_n, frame_n, irdy_n;
    logic req_n, start, owner, lt_expired;
    modport master (
        input  xfer_req, xfer_done, gnt_n, frame_n, irdy_n,
        output req_n, start, owner, lt_expired
    );
    modport slave (
        output xfer_req, xfer_done, gnt_n, frame_n, irdy_n,
        input  req_n, start, owner, lt_expired
    );
endinterface

// File: rtl/pci_lat_timer.sv
// pci_lat_timer: loadable counter, saturating at LIMIT counting up or at 0 counting down
module pci_lat_timer #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);
    assign expired = up ? (cnt == CNT_W'(LIMIT)) : (cnt == '0);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && !expired) cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
endmodule

// File: rtl/pci_bus_requester.sv
// pci_bus_requester: master side of the PCI REQ#/GNT# handshake with latency timer
module pci_bus_requester
    import pci_arb_pkg::*;
#(
    parameter int LAT_TIMER = 16,
    parameter int REQ_GAP   = 2,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    pci_bus_requester_if.master        bus
);
    req_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat, bus_idle, grant_ok, release_bus;
    assign bus_idle    = bus.frame_n & bus.irdy_n;
    assign grant_ok    = state == REQ && bus.xfer_req && bus.gnt_n == ASSERTED_N && bus_idle;
    assign release_bus = state == OWN && bus.xfer_done;
    // One counter serves both phases: up as lat_cnt in OWN, down as gap_cnt otherwise
    pci_lat_timer #(.CNT_W(CNT_W), .LIMIT(LAT_TIMER)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_ok),
        .load     (release_bus),
        .load_val (CNT_W'(REQ_GAP)),
        .en       (state == OWN || state == GAP),
        .up       (state == OWN),
        .cnt      (cnt),
        .expired  (cnt_sat)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.req_n      <= DEASSERTED_N;
            bus.start      <= 1'b0;
            bus.owner      <= 1'b0;
            bus.lt_expired <= 1'b0;
        end else begin
            bus.start <= 1'b0;
            case (state)
                IDLE: if (bus.xfer_req && cnt_sat) begin
                    state     <= REQ;
                    bus.req_n <= ASSERTED_N;
                end
                REQ: if (!bus.xfer_req) begin
                    state     <= IDLE;
                    bus.req_n <= DEASSERTED_N;
                end else if (grant_ok) begin
                    state          <= OWN;
                    bus.start      <= 1'b1;
                    bus.owner      <= 1'b1;
                    bus.lt_expired <= 1'b0;
                end
                OWN: if (bus.xfer_done) begin
                    state          <= GAP;
                    bus.req_n      <= DEASSERTED_N;
                    bus.owner      <= 1'b0;
                    bus.lt_expired <= 1'b0;
                end else bus.lt_expired <= cnt_sat & bus.gnt_n;
                GAP: if (cnt <= CNT_W'(1)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_bus_requester.sv
// tb_pci_bus_requester: directed vector table plus latency, gap and reset sequences
module tb_pci_bus_requester;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pci_bus_requester_if bus();
    pci_bus_requester #(.LAT_TIMER(16), .REQ_GAP(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    // inputs {rst, xfer_req, xfer_done, gnt_n, frame_n, irdy_n}, expected {req_n, start, owner, lt_expired} after the edge
    typedef struct packed {
        logic       r, xr, xd, g, f, i;
        logic [3:0] e;
    } vec_t;
    int errors = 0;
    int checks = 0;
    task automatic drive(input logic r, xr, xd, g, f, i);
        rst = r;
        bus.xfer_req = xr;
        bus.xfer_done = xd;
        bus.gnt_n = g;
        bus.frame_n = f;
        bus.irdy_n = i;
    endtask
    task automatic step_check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        @(posedge clk);
        #1;
        got = {bus.req_n, bus.start, bus.owner, bus.lt_expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: req_n/start/owner/lt_expired got %b expected %b", name, got, exp);
        end
    endtask
    initial begin
        vec_t v[26];
        v = '{
            10'b100111_1000, 10'b100111_1000,
            10'b010111_0000, 10'b010111_0000, 10'b010011_0110, 10'b010011_0010,
            10'b011011_1000, 10'b010111_1000, 10'b010111_1000, 10'b010111_0000,
            10'b010001_0000, 10'b010000_0000, 10'b010010_0000, 10'b010001_0000,
            10'b010011_0110, 10'b010011_0010, 10'b011011_1000,
            10'b000111_1000, 10'b000111_1000, 10'b001011_1000,
            10'b010111_0000, 10'b000111_1000, 10'b010111_0000,
            10'b011001_0000, 10'b010111_0000, 10'b010011_0110
        };
        for (int k = 0; k < 26; k++) begin
            drive(v[k].r, v[k].xr, v[k].xd, v[k].g, v[k].f, v[k].i);
            step_check($sformatf("vec%0d", k), v[k].e);
        end
        // Owning since vec25; gnt_n removed at ownership clock 10
        drive(0, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            step_check($sformatf("own_clk%0d", k), 4'b0010);
            if (k == 10) bus.gnt_n = 1'b1;
        end
        step_check("lt_expired_set", 4'b0011);
        bus.gnt_n = 1'b0;
        step_check("lt_regrant_clears", 4'b0010);
        bus.gnt_n = 1'b1;
        step_check("lt_expired_again", 4'b0011);
        bus.xfer_done = 1'b1;
        step_check("done_beats_expiry", 4'b1000);
        bus.xfer_done = 1'b0;
        step_check("gap_1", 4'b1000);
        step_check("gap_2", 4'b1000);
        step_check("gap_rerequest", 4'b0000);
        bus.gnt_n = 1'b0;
        step_check("own_again", 4'b0110);
        for (int k = 1; k <= 7; k++) step_check($sformatf("pre_rst_clk%0d", k), 4'b0010);
        rst = 1'b1;
        step_check("reset_mid_own", 4'b1000);
        drive(0, 0, 0, 0, 1, 1);
        step_check("idle_after_reset", 4'b1000);
        bus.xfer_req = 1'b1;
        step_check("request_after_reset", 4'b0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
